// File: rtl/iob_iob2wishbone_burst.sv
// rtl/iob_iob2wishbone_burst.sv - IOb slave to Wishbone B4 master bridge with posted writes and incrementing bursts
//
// Ports:
//   clk_i, arst_n_i                 clock, asynchronous active-low reset
//   valid_i, addr_i, wdata_i,
//   wstrb_i, ready_o                IOb request (wstrb != 0 is a write)
//   rdata_o, rvalid_o, rerr_o       IOb read completion (one-cycle pulse)
//   werr_o, werr_clr_i              sticky posted-write error and its clear
//   busy_o                          FIFO non-empty or Wishbone cycle open
//   wb_*                            Wishbone B4 master (registered-feedback CTI/BTE)
module iob_iob2wishbone_burst #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int FIFO_AW   = 2,
  parameter int MAX_BURST = 4,
  parameter int TIMEOUT_W = 8
) (
  input  logic                  clk_i,
  input  logic                  arst_n_i,
  input  logic                  valid_i,
  input  logic [ADDR_W-1:0]     addr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic [DATA_W/8-1:0]   wstrb_i,
  output logic                  ready_o,
  output logic [DATA_W-1:0]     rdata_o,
  output logic                  rvalid_o,
  output logic                  rerr_o,
  output logic                  werr_o,
  input  logic                  werr_clr_i,
  output logic                  busy_o,
  output logic [ADDR_W-1:0]     wb_adr_o,
  output logic [DATA_W/8-1:0]   wb_sel_o,
  output logic                  wb_we_o,
  output logic [DATA_W-1:0]     wb_dat_o,
  input  logic [DATA_W-1:0]     wb_dat_i,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  input  logic                  wb_ack_i,
  input  logic                  wb_err_i,
  output logic [2:0]            wb_cti_o,
  output logic [1:0]            wb_bte_o
);

  localparam int SEL_W  = DATA_W / 8;
  localparam int DEPTH  = 1 << FIFO_AW;
  localparam int BEAT_W = $clog2(MAX_BURST + 1);

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  localparam logic [FIFO_AW:0]     CNT_ONE   = 1;
  localparam logic [FIFO_AW:0]     CNT_TWO   = 2;
  localparam logic [FIFO_AW:0]     CNT_FULL  = DEPTH[FIFO_AW:0];
  localparam logic [FIFO_AW-1:0]   PTR_ONE   = 1;
  localparam logic [FIFO_AW-1:0]   PTR_TWO   = FIFO_AW'(2);
  localparam logic [BEAT_W-1:0]    BEAT_LAST = BEAT_W'(MAX_BURST - 1);
  localparam logic [ADDR_W:0]      ADDR_STEP = (ADDR_W + 1)'(SEL_W);
  // The counter trips on the wait cycle that would take it to all-ones.
  localparam logic [TIMEOUT_W-1:0] TMO_LAST  = {{(TIMEOUT_W - 1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_GAP
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0]  fifo_addr [DEPTH];
  logic [DATA_W-1:0]  fifo_data [DEPTH];
  logic [SEL_W-1:0]   fifo_strb [DEPTH];
  logic [FIFO_AW-1:0] rd_ptr_q, wr_ptr_q, ptr1, ptr2;
  logic [FIFO_AW:0]   count_q;

  logic [2:0]           cti_q, cti_d;
  logic [BEAT_W-1:0]    beat_q, beat_d, beat_nxt;
  logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
  logic [ADDR_W-1:0]    rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;
  logic                 rvalid_q, rvalid_d, rerr_q, rerr_d, werr_q, werr_d;

  logic is_write, empty, full, in_wr, in_rd, cyc, tmo, err_ev, ack_ev;
  logic push, pop, rd_acc;
  logic avail1, avail2, contig01, contig12;
  logic [ADDR_W-1:0] addr0, addr1, addr2;
  logic [2:0] cti_launch, cti_adv;

  assign is_write = |wstrb_i;
  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_FULL);
  assign in_wr    = (state_q == S_WR);
  assign in_rd    = (state_q == S_RD);
  assign cyc      = in_wr | in_rd;

  // err beats ack, and an expired wait counts as an err
  assign tmo    = cyc && !wb_ack_i && !wb_err_i && (tmo_q == TMO_LAST);
  assign err_ev = cyc && (wb_err_i || tmo);
  assign ack_ev = cyc && wb_ack_i && !wb_err_i;

  assign pop     = in_wr && (ack_ev || err_ev);
  assign push    = valid_i && is_write && (!full || pop);
  assign rd_acc  = valid_i && !is_write && (state_q == S_IDLE) && empty;
  assign ready_o = push | rd_acc;

  // Look-ahead at the entries behind the head. An entry being pushed this
  // cycle counts, so back-to-back writes can open a burst straight away.
  always_comb begin
    ptr1     = rd_ptr_q + PTR_ONE;
    ptr2     = rd_ptr_q + PTR_TWO;
    addr0    = fifo_addr[rd_ptr_q];
    avail1   = (count_q > CNT_ONE) || ((count_q == CNT_ONE) && push);
    addr1    = (count_q > CNT_ONE) ? fifo_addr[ptr1] : addr_i;
    avail2   = (count_q > CNT_TWO) || ((count_q == CNT_TWO) && push);
    addr2    = (count_q > CNT_TWO) ? fifo_addr[ptr2] : addr_i;
    // One extra bit so an increment that wraps the address space never matches
    contig01 = (({1'b0, addr0} + ADDR_STEP) == {1'b0, addr1});
    contig12 = (({1'b0, addr1} + ADDR_STEP) == {1'b0, addr2});
    beat_nxt = beat_q + BEAT_W'(1);
    cti_launch = (avail1 && contig01) ? CTI_INCR : CTI_CLASSIC;
    cti_adv    = (avail2 && contig12 && (beat_nxt < BEAT_LAST)) ? CTI_INCR : CTI_END;
  end

  always_comb begin
    state_d   = state_q;
    cti_d     = cti_q;
    beat_d    = beat_q;
    rd_addr_d = rd_addr_q;
    rdata_d   = rdata_q;
    rvalid_d  = 1'b0;
    rerr_d    = 1'b0;
    werr_d    = werr_clr_i ? 1'b0 : werr_q;
    tmo_d     = (cyc && !wb_ack_i && !wb_err_i && !tmo) ? tmo_q + TIMEOUT_W'(1) : '0;

    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          state_d = S_WR;
          cti_d   = cti_launch;
          beat_d  = '0;
        end else if (rd_acc) begin
          state_d   = S_RD;
          rd_addr_d = addr_i;
        end
      end
      S_WR: begin
        if (err_ev) begin
          werr_d  = 1'b1;
          state_d = S_IDLE;
        end else if (ack_ev) begin
          if (cti_q == CTI_INCR) begin
            cti_d  = cti_adv;
            beat_d = beat_nxt;
          end else begin
            state_d = S_GAP;
          end
        end
      end
      S_RD: begin
        if (err_ev) begin
          rvalid_d = 1'b1;
          rerr_d   = 1'b1;
          rdata_d  = '0;
          state_d  = S_IDLE;
        end else if (ack_ev) begin
          rvalid_d = 1'b1;
          rdata_d  = wb_dat_i;
          state_d  = S_IDLE;
        end
      end
      S_GAP: begin
        if (!empty) begin
          state_d = S_WR;
          cti_d   = cti_launch;
          beat_d  = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q   <= S_IDLE;
      cti_q     <= CTI_CLASSIC;
      beat_q    <= '0;
      tmo_q     <= '0;
      rd_addr_q <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      rerr_q    <= 1'b0;
      werr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cti_q     <= cti_d;
      beat_q    <= beat_d;
      tmo_q     <= tmo_d;
      rd_addr_q <= rd_addr_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
      rerr_q    <= rerr_d;
      werr_q    <= werr_d;
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: only entries between the pointers are ever used
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_addr[wr_ptr_q] <= addr_i;
      fifo_data[wr_ptr_q] <= wdata_i;
      fifo_strb[wr_ptr_q] <= wstrb_i;
    end
  end

  assign wb_cyc_o = cyc;
  assign wb_stb_o = cyc;
  assign wb_we_o  = in_wr;
  assign wb_adr_o = in_wr ? fifo_addr[rd_ptr_q] : (in_rd ? rd_addr_q : '0);
  assign wb_sel_o = in_wr ? fifo_strb[rd_ptr_q] : (in_rd ? {SEL_W{1'b1}} : '0);
  assign wb_dat_o = in_wr ? fifo_data[rd_ptr_q] : '0;
  assign wb_cti_o = in_wr ? cti_q : CTI_CLASSIC;
  assign wb_bte_o = 2'b00;

  assign busy_o   = !empty | cyc;
  assign rdata_o  = rdata_q;
  assign rvalid_o = rvalid_q;
  assign rerr_o   = rerr_q;
  assign werr_o   = werr_q;

endmodule

// File: tb/tb_iob_iob2wishbone_burst.sv
// tb/tb_iob_iob2wishbone_burst.sv - self-checking bench for iob_iob2wishbone_burst
module tb_iob_iob2wishbone_burst;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        valid = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        ready;
  logic [31:0] rdata;
  logic        rvalid, rerr, werr;
  logic        werr_clr = 1'b0;
  logic        busy;
  logic [31:0] wb_adr;
  logic [3:0]  wb_sel;
  logic        wb_we;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i = '0;
  logic        wb_cyc, wb_stb;
  logic        wb_ack = 1'b0;
  logic        wb_err = 1'b0;
  logic [2:0]  wb_cti;
  logic [1:0]  wb_bte;

  always #5 clk = ~clk;

  iob_iob2wishbone_burst dut (
    .clk_i(clk), .arst_n_i(arst_n),
    .valid_i(valid), .addr_i(addr), .wdata_i(wdata), .wstrb_i(wstrb), .ready_o(ready),
    .rdata_o(rdata), .rvalid_o(rvalid), .rerr_o(rerr), .werr_o(werr), .werr_clr_i(werr_clr),
    .busy_o(busy), .wb_adr_o(wb_adr), .wb_sel_o(wb_sel), .wb_we_o(wb_we), .wb_dat_o(wb_dat_o),
    .wb_dat_i(wb_dat_i), .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_ack_i(wb_ack),
    .wb_err_i(wb_err), .wb_cti_o(wb_cti), .wb_bte_o(wb_bte)
  );

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [2:0]  cti;
  } wbeat_t;

  typedef struct packed {
    logic [31:0] dat;
    logic        err;
  } rresp_t;

  wbeat_t exp_wq[$];
  rresp_t exp_rq[$];

  int checks = 0;
  int errors = 0;
  int cyc_rises = 0;
  int stb_cycles = 0;
  int wr_done = 0;
  logic cyc_prev = 1'b0;

  bit ack_en = 1'b1;
  int err_cd = -1;

  function automatic logic [31:0] slave_data(input logic [31:0] a);
    return {a[15:0], 16'hBEEF};
  endfunction

  // Slave: answers one cycle in two while stb is high; err_cd counts handshakes down to an err
  always begin
    @(posedge clk);
    #1;
    if (!arst_n) begin
      wb_ack = 1'b0;
      wb_err = 1'b0;
    end else if (wb_cyc && wb_stb && !wb_ack && !wb_err && ack_en) begin
      if (err_cd == 0) begin
        wb_err = 1'b1;
        err_cd = -1;
      end else begin
        wb_ack = 1'b1;
        if (err_cd > 0) err_cd--;
      end
    end else begin
      wb_ack = 1'b0;
      wb_err = 1'b0;
    end
    wb_dat_i = slave_data(wb_adr);
  end

  // Scoreboard side: pop expected beats and read responses as the DUT completes them
  always @(negedge clk) begin
    wbeat_t e, g;
    rresp_t r, rg;
    if (arst_n) begin
      if (wb_cyc && !cyc_prev) cyc_rises++;
      if (wb_stb) stb_cycles++;
      if (wb_cyc && wb_we && (wb_ack || wb_err)) begin
        if (wb_ack) wr_done++;
        checks++;
        g = '{adr: wb_adr, dat: wb_dat_o, sel: wb_sel, cti: wb_cti};
        if (exp_wq.size() == 0) begin
          errors++;
          $display("FAIL wb_beat_unexpected: got adr=%h dat=%h sel=%h cti=%b, none required", wb_adr, wb_dat_o, wb_sel, wb_cti);
        end else begin
          e = exp_wq.pop_front();
          if (g !== e) begin
            errors++;
            $display("FAIL wb_beat: got adr=%h dat=%h sel=%h cti=%b, required adr=%h dat=%h sel=%h cti=%b",
                     g.adr, g.dat, g.sel, g.cti, e.adr, e.dat, e.sel, e.cti);
          end
        end
      end
      if (rvalid) begin
        checks++;
        rg = '{dat: rdata, err: rerr};
        if (exp_rq.size() == 0) begin
          errors++;
          $display("FAIL read_unexpected: got rdata=%h rerr=%b, none required", rdata, rerr);
        end else begin
          r = exp_rq.pop_front();
          if (rg !== r) begin
            errors++;
            $display("FAIL read_resp: got rdata=%h rerr=%b, required rdata=%h rerr=%b", rdata, rerr, r.dat, r.err);
          end
        end
      end
    end
    cyc_prev = wb_cyc;
  end

  task automatic idle_in();
    @(posedge clk);
    #2;
    valid = 1'b0;
    wstrb = '0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                    input logic [2:0] cti, input bit expect_beat, output int waited);
    @(posedge clk);
    #2;
    valid = 1'b1; addr = a; wdata = d; wstrb = s;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (ready) begin
        if (expect_beat) exp_wq.push_back('{adr: a, dat: d, sel: s, cti: cti});
        waited = i;
        return;
      end
    end
    waited = 300;
    checks++; errors++;
    $display("FAIL wr_accept: addr %h got no ready_o in 300 cycles, required ready_o=1", a);
  endtask

  task automatic rd(input logic [31:0] a, output int acked_before);
    @(posedge clk);
    #2;
    valid = 1'b1; addr = a; wdata = '0; wstrb = '0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (ready) begin
        exp_rq.push_back('{dat: slave_data(a), err: 1'b0});
        acked_before = wr_done;
        return;
      end
    end
    acked_before = -1;
    checks++; errors++;
    $display("FAIL rd_accept: addr %h got no ready_o in 300 cycles, required ready_o=1", a);
  endtask

  task automatic wait_idle(input string name);
    bit done = 1'b0;
    idle_in();
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (!busy && !rvalid && exp_rq.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_drain: got busy_o=%b after 600 cycles, required 0", name, busy);
    end
    checks++;
    if (exp_wq.size() != 0) begin
      errors++;
      $display("FAIL %s_beats_left: got %0d beats outstanding, required 0", name, exp_wq.size());
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({ready, rvalid, rerr, werr, busy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_iob: got ready/rvalid/rerr/werr/busy=%b, required 00000", {ready, rvalid, rerr, werr, busy});
    end
    checks++;
    if ({wb_cyc, wb_stb, wb_we} !== 3'b0) begin
      errors++;
      $display("FAIL reset_wb_ctl: got cyc/stb/we=%b, required 000", {wb_cyc, wb_stb, wb_we});
    end
    checks++;
    if ({wb_adr, wb_sel, wb_dat_o} !== 68'b0) begin
      errors++;
      $display("FAIL reset_wb_bus: got adr=%h sel=%h dat=%h, required all 0", wb_adr, wb_sel, wb_dat_o);
    end
    checks++;
    if ({wb_cti, wb_bte} !== 5'b0 || rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_misc: got cti=%b bte=%b rdata=%h, required 0", wb_cti, wb_bte, rdata);
    end
    @(posedge clk);
    #2;
    arst_n = 1'b1;
  endtask

  task automatic test_burst();
    int w;
    int base = cyc_rises;
    logic [2:0] ctis [4];
    ctis = '{3'b010, 3'b010, 3'b010, 3'b111};
    for (int i = 0; i < 4; i++)
      wr(32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i), 4'hF, ctis[i], 1'b1, w);
    wait_idle("burst");
    checks++;
    if (cyc_rises - base != 1) begin
      errors++;
      $display("FAIL burst_cycles: got %0d cycles, required 1", cyc_rises - base);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL burst_busy: got busy_o=%b, required 0", busy);
    end
  endtask

  task automatic test_separate();
    int w;
    int base = cyc_rises;
    wr(32'h100, 32'h1111_2222, 4'h3, 3'b000, 1'b1, w);
    wr(32'h200, 32'h3333_4444, 4'hC, 3'b000, 1'b1, w);
    wait_idle("separate");
    checks++;
    if (cyc_rises - base != 2) begin
      errors++;
      $display("FAIL separate_cycles: got %0d cycles, required 2", cyc_rises - base);
    end
  endtask

  task automatic test_fifo_full();
    int w;
    bit stalled = 1'b1;
    bit got = 1'b0;
    logic ack_at = 1'b0;
    logic [2:0] ctis [4];
    ctis = '{3'b010, 3'b010, 3'b010, 3'b111};
    ack_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wr(32'h800 + 32'(4 * i), 32'hB000_0000 + 32'(i), 4'hF, ctis[i], 1'b1, w);
      checks++;
      if (w != 0) begin
        errors++;
        $display("FAIL full_accept%0d: got ready_o after %0d cycles, required immediately", i, w);
      end
    end
    @(posedge clk);
    #2;
    valid = 1'b1; addr = 32'h810; wdata = 32'hB000_0004; wstrb = 4'hF;
    repeat (10) begin
      @(negedge clk);
      if (ready) stalled = 1'b0;
    end
    checks++;
    if (!stalled) begin
      errors++;
      $display("FAIL full_stall: got ready_o=1 with FIFO full and no ack, required 0");
    end
    ack_en = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ready) begin
        got = 1'b1;
        ack_at = wb_ack;
        exp_wq.push_back('{adr: 32'h810, dat: 32'hB000_0004, sel: 4'hF, cti: 3'b000});
        break;
      end
    end
    checks++;
    if (!got || ack_at !== 1'b1) begin
      errors++;
      $display("FAIL full_release: got accepted=%b wb_ack_i=%b, required 1 and 1", got, ack_at);
    end
    wait_idle("full");
  endtask

  task automatic test_read_after_writes();
    int w, acked;
    int base = wr_done;
    wr(32'h500, 32'hC000_0001, 4'hF, 3'b000, 1'b1, w);
    wr(32'h600, 32'hC000_0002, 4'hF, 3'b000, 1'b1, w);
    rd(32'h300, acked);
    checks++;
    if (acked - base != 2) begin
      errors++;
      $display("FAIL read_order: got %0d write acks before read accept, required 2", acked - base);
    end
    wait_idle("read");
  endtask

  task automatic test_timeout();
    int w;
    bit closed = 1'b0;
    ack_en = 1'b0;
    wr(32'h400, 32'hD000_0000, 4'hF, 3'b000, 1'b0, w);
    idle_in();
    stb_cycles = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (!wb_cyc && stb_cycles > 0) begin
        closed = 1'b1;
        break;
      end
    end
    checks++;
    if (!closed || stb_cycles != 255) begin
      errors++;
      $display("FAIL timeout_len: got closed=%b after %0d stb cycles, required 1 after 255", closed, stb_cycles);
    end
    checks++;
    if (werr !== 1'b1) begin
      errors++;
      $display("FAIL timeout_werr: got werr_o=%b, required 1", werr);
    end
    ack_en = 1'b1;
    @(posedge clk); #2; werr_clr = 1'b1;
    @(posedge clk); #2; werr_clr = 1'b0;
    @(negedge clk);
    checks++;
    if (werr !== 1'b0) begin
      errors++;
      $display("FAIL werr_clear: got werr_o=%b, required 0", werr);
    end
    wait_idle("timeout");
  endtask

  task automatic test_err_burst();
    int w;
    int base = cyc_rises;
    logic [2:0] ctis [4];
    ctis = '{3'b010, 3'b010, 3'b010, 3'b111};
    err_cd = 1;
    for (int i = 0; i < 4; i++)
      wr(32'h900 + 32'(4 * i), 32'hE000_0000 + 32'(i), 4'hF, ctis[i], 1'b1, w);
    wait_idle("errburst");
    checks++;
    if (cyc_rises - base != 2 || werr !== 1'b1) begin
      errors++;
      $display("FAIL errburst: got %0d cycles werr_o=%b, required 2 cycles werr_o=1", cyc_rises - base, werr);
    end
    @(posedge clk); #2; werr_clr = 1'b1;
    @(posedge clk); #2; werr_clr = 1'b0;
  endtask

  task automatic test_reset_mid();
    int w;
    bit seen = 1'b0;
    bit quiet = 1'b1;
    ack_en = 1'b0;
    wr(32'h700, 32'hF000_0000, 4'hF, 3'b000, 1'b0, w);
    wr(32'h704, 32'hF000_0001, 4'hF, 3'b000, 1'b0, w);
    idle_in();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (wb_cyc) begin
        seen = 1'b1;
        break;
      end
    end
    #3;
    arst_n = 1'b0;
    #1;
    checks++;
    if (!seen || wb_cyc !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got cyc_seen=%b cyc_o=%b busy_o=%b, required 1 0 0", seen, wb_cyc, busy);
    end
    repeat (2) @(posedge clk);
    #2;
    arst_n = 1'b1;
    ack_en = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (wb_cyc || busy) quiet = 1'b0;
    end
    checks++;
    if (!quiet) begin
      errors++;
      $display("FAIL reset_discard: got bus activity after reset, required none");
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_burst();
    test_separate();
    test_fifo_full();
    test_read_after_writes();
    test_timeout();
    test_err_burst();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
